// File: rtl/pal_ctrl_pkg.sv
// rtl/pal_ctrl_pkg.sv - shared widths, FSM state and queue entry type for the palette write controller
package pal_ctrl_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 24;

  typedef enum logic [1:0] {
    IDLE,
    RELOAD,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } pal_entry_t;

endpackage

// File: rtl/palette_update_ctrl_if.sv
// rtl/palette_update_ctrl_if.sv - host single-entry palette write handshake
interface palette_update_ctrl_if
  import pal_ctrl_pkg::*;
;
  logic              host_valid;
  logic              host_ready;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_data;

  modport master (
    output host_valid,
    output host_addr,
    output host_data,
    input  host_ready
  );

  modport slave (
    input  host_valid,
    input  host_addr,
    input  host_data,
    output host_ready
  );

endinterface

// File: rtl/pal_wr_fifo.sv
// rtl/pal_wr_fifo.sv - synchronous queue of pending host palette writes
module pal_wr_fifo
  import pal_ctrl_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             push,
  input  pal_entry_t       push_data,
  input  logic             pop,
  output pal_entry_t       pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  pal_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wptr_q;
  logic [PTR_W-1:0] rptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             full_q;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push & ~full_q;
  assign pop_ok  = pop & (count_q != '0);
  assign count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);

  // full resets high so the queue refuses writes until the first clock after reset
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b1;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PTR_W'(1);
      if (pop_ok)  rptr_q <= rptr_q + PTR_W'(1);
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge Clk) begin
    if (push_ok) mem[wptr_q] <= push_data;
  end

  assign pop_data = mem[rptr_q];
  assign full     = full_q;
  assign empty    = (count_q == '0);
  assign count    = count_q;

endmodule

// File: rtl/palette_update_ctrl.sv
// rtl/palette_update_ctrl.sv - arbitrates host queue and bulk ROM reload onto the palette write port during vblank
module palette_update_ctrl
  import pal_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic                          vblank,
  palette_update_ctrl_if.slave          host,
  input  logic                          reload_req,
  output logic                          reload_busy,
  output logic                          reload_done,
  output logic [ADDR_W-1:0]             src_addr,
  input  logic [DATA_W-1:0]             src_data,
  output logic                          pal_we,
  output logic [ADDR_W-1:0]             pal_waddr,
  output logic [DATA_W-1:0]             pal_wdata,
  output logic [$clog2(FIFO_DEPTH):0]   q_count
);

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W:0]   k_q;
  logic [ADDR_W:0]   k_d;
  logic              v1_q;
  logic              v2_q;
  logic [ADDR_W-1:0] a2_q;
  logic              last_wr_q;
  logic              busy_q;
  logic              done_q;
  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [ADDR_W-1:0] src_addr_q;
  logic              issue;
  logic              pop;
  logic              push;
  logic              rl_pend;
  logic              fifo_full;
  logic              fifo_empty;
  pal_entry_t        head;
  pal_entry_t        push_entry;

  assign push       = host.host_valid & host.host_ready;
  assign push_entry = '{addr: host.host_addr, data: host.host_data};
  assign host.host_ready = ~fifo_full;

  pal_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (q_count)
  );

  // A request arriving in this cycle may start the reload immediately, before busy is visible
  assign rl_pend = busy_q | reload_req;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    issue   = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (vblank && rl_pend) begin
          state_d = RELOAD;
          issue   = 1'b1;
        end else if (vblank && !fifo_empty) begin
          state_d = DRAIN;
        end
      end
      RELOAD: begin
        if (last_wr_q) begin
          k_d     = '0;
          state_d = (vblank && !fifo_empty) ? DRAIN : IDLE;
        end else if (vblank && !k_q[ADDR_W]) begin
          issue = 1'b1;
        end
      end
      DRAIN: begin
        if (vblank && !fifo_empty) pop = 1'b1;
        else                       state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (issue) k_d = k_q + (ADDR_W+1)'(1);
  end

  // Issue -> ROM address -> ROM data -> palette write; the reload and drain paths never overlap
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      k_q        <= '0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      a2_q       <= '0;
      src_addr_q <= '0;
      last_wr_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      v1_q      <= issue;
      if (issue) src_addr_q <= k_q[ADDR_W-1:0];
      v2_q      <= v1_q;
      a2_q      <= src_addr_q;
      last_wr_q <= v2_q && (a2_q == '1);
      done_q    <= last_wr_q;
      if (last_wr_q)       busy_q <= 1'b0;
      else if (reload_req) busy_q <= 1'b1;
      we_q <= v2_q | pop;
      if (v2_q) begin
        waddr_q <= a2_q;
        wdata_q <= src_data;
      end else if (pop) begin
        waddr_q <= head.addr;
        wdata_q <= head.data;
      end
    end
  end

  assign reload_busy = busy_q;
  assign reload_done = done_q;
  assign src_addr    = src_addr_q;
  assign pal_we      = we_q;
  assign pal_waddr   = waddr_q;
  assign pal_wdata   = wdata_q;

endmodule

// File: tb/tb_palette_update_ctrl.sv
// tb/tb_palette_update_ctrl.sv - directed self-checking bench for palette_update_ctrl
module tb_palette_update_ctrl;
  import pal_ctrl_pkg::*;

  logic              Clk = 1'b0;
  logic              Reset_n = 1'b0;
  logic              vblank = 1'b0;
  logic              reload_req = 1'b0;
  logic              reload_busy;
  logic              reload_done;
  logic [ADDR_W-1:0] src_addr;
  logic [DATA_W-1:0] src_data = '0;
  logic              pal_we;
  logic [ADDR_W-1:0] pal_waddr;
  logic [DATA_W-1:0] pal_wdata;
  logic [4:0]        q_count;

  palette_update_ctrl_if hif ();

  palette_update_ctrl #(.FIFO_DEPTH(16)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .vblank      (vblank),
    .host        (hif),
    .reload_req  (reload_req),
    .reload_busy (reload_busy),
    .reload_done (reload_done),
    .src_addr    (src_addr),
    .src_data    (src_data),
    .pal_we      (pal_we),
    .pal_waddr   (pal_waddr),
    .pal_wdata   (pal_wdata),
    .q_count     (q_count)
  );

  always #5 Clk = ~Clk;

  // identity source ROM with one cycle of read latency
  always @(posedge Clk) src_data <= {3{src_addr}};

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int wa_q[$];
  int wd_q[$];
  int wc_q[$];
  int done_cnt = 0;
  int done_cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  always @(negedge Clk) begin
    if (Reset_n && pal_we) begin
      wa_q.push_back(int'(pal_waddr));
      wd_q.push_back(int'(pal_wdata));
      wc_q.push_back(cyc);
    end
    if (Reset_n && reload_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
    #1;
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
    done_cnt = 0;
  endtask

  task automatic host_write(input logic [7:0] a, input logic [23:0] d);
    int n = 0;
    hif.host_valid = 1'b1;
    hif.host_addr  = a;
    hif.host_data  = d;
    while (!hif.host_ready && n < 200) begin
      tick();
      n++;
    end
    tick();
    hif.host_valid = 1'b0;
    if (n >= 200) check("host_write_timeout", 32'(n), 32'd0);
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 700) begin
      tick();
      n++;
    end
    if (n >= 700) check("reload_done_timeout", 32'(done_cnt), 32'(target));
  endtask

  initial begin
    int p;
    int fall_cyc;
    int bad;
    hif.host_valid = 1'b0;
    hif.host_addr  = '0;
    hif.host_data  = '0;

    // reset state
    repeat (3) tick();
    check("rst_outputs", {hif.host_ready, reload_busy, reload_done, pal_we, q_count, pal_waddr, src_addr}, 32'd0);
    check("rst_wdata", 32'(pal_wdata), 32'd0);
    Reset_n = 1'b1;
    tick();
    check("ready_after_rst", 32'(hif.host_ready), 32'd1);

    // three host writes held off until vblank
    host_write(8'h05, 24'hFF0000);
    host_write(8'h06, 24'h00FF00);
    host_write(8'h07, 24'h0000FF);
    repeat (2) tick();
    check("no_we_outside_vblank", 32'(wa_q.size()), 32'd0);
    check("q_count_3", 32'(q_count), 32'd3);
    vblank = 1'b1;
    repeat (8) tick();
    check("drain3_count", 32'(wa_q.size()), 32'd3);
    if (wa_q.size() == 3) begin
      check("drain3_a0", 32'({wa_q[0][7:0], wd_q[0][23:0]}), 32'h05FF0000);
      check("drain3_a1", 32'({wa_q[1][7:0], wd_q[1][23:0]}), 32'h0600FF00);
      check("drain3_a2", 32'({wa_q[2][7:0], wd_q[2][23:0]}), 32'h070000FF);
      check("drain3_back_to_back", 32'(wc_q[2] - wc_q[0]), 32'd2);
    end
    check("q_count_0", 32'(q_count), 32'd0);
    vblank = 1'b0;
    tick();
    clear_log();

    // fill the queue, then a 17th write waits for a drain slot
    for (int i = 0; i < 16; i++) host_write(8'(8'h20 + i), 24'(24'h010101 * i));
    check("full_ready_low", 32'(hif.host_ready), 32'd0);
    check("full_q_count", 32'(q_count), 32'd16);
    vblank = 1'b1;
    host_write(8'h40, 24'h404040);
    begin
      int n = 0;
      while (q_count != 0 && n < 100) begin tick(); n++; end
    end
    repeat (3) tick();
    vblank = 1'b0;
    check("fill17_count", 32'(wa_q.size()), 32'd17);
    bad = 0;
    for (int i = 0; i < wa_q.size() && i < 17; i++) begin
      if (i < 16 && (wa_q[i] != 32'h20 + i || wd_q[i] != 32'h010101 * i)) bad++;
      if (i == 16 && (wa_q[i] != 32'h40 || wd_q[i] != 32'h404040)) bad++;
    end
    check("fill17_order", 32'(bad), 32'd0);
    tick();
    clear_log();

    // uninterrupted reload with identity ROM
    vblank = 1'b1;
    reload_req = 1'b1;
    p = cyc;
    tick();
    reload_req = 1'b0;
    check("busy_after_req", 32'(reload_busy), 32'd1);
    wait_done(1);
    repeat (4) tick();
    check("reload_we_count", 32'(wa_q.size()), 32'd256);
    bad = 0;
    for (int i = 0; i < wa_q.size() && i < 256; i++)
      if (wa_q[i] != i || wd_q[i] != (i * 32'h010101)) bad++;
    check("reload_identity", 32'(bad), 32'd0);
    check("reload_done_latency", 32'(done_cyc - p), 32'd259);
    check("reload_done_once", 32'(done_cnt), 32'd1);
    if (wc_q.size() > 0) check("done_after_last_we", 32'(done_cyc - wc_q[wc_q.size()-1]), 32'd1);
    check("busy_cleared", 32'(reload_busy), 32'd0);
    vblank = 1'b0;
    tick();
    clear_log();

    // reload interrupted after 100 issues, host write queued meanwhile
    vblank = 1'b1;
    reload_req = 1'b1;
    tick();
    reload_req = 1'b0;
    repeat (99) tick();
    vblank = 1'b0;
    fall_cyc = cyc;
    host_write(8'h10, 24'hABCDEF);
    repeat (6) tick();
    check("stall_we_count", 32'(wa_q.size()), 32'd100);
    if (wc_q.size() > 0) begin
      check("stall_last_addr", 32'(wa_q[wa_q.size()-1]), 32'd99);
      check("stall_we_stop", 32'(wc_q[wc_q.size()-1] <= fall_cyc + 2), 32'd1);
    end
    check("stall_busy", 32'(reload_busy), 32'd1);
    vblank = 1'b1;
    wait_done(1);
    repeat (6) tick();
    check("resume_count", 32'(wa_q.size()), 32'd257);
    bad = 0;
    for (int i = 0; i < wa_q.size() && i < 256; i++)
      if (wa_q[i] != i || wd_q[i] != (i * 32'h010101)) bad++;
    check("resume_sequence", 32'(bad), 32'd0);
    if (wa_q.size() == 257) begin
      check("host_override", 32'({wa_q[256][7:0], wd_q[256][23:0]}), 32'h10ABCDEF);
      check("host_after_done", 32'(wc_q[256] > done_cyc), 32'd1);
    end
    vblank = 1'b0;
    tick();
    clear_log();

    // asynchronous reset in the middle of a reload
    vblank = 1'b1;
    reload_req = 1'b1;
    tick();
    reload_req = 1'b0;
    repeat (49) tick();
    #2;
    Reset_n = 1'b0;
    #1;
    check("midrst_outputs", {hif.host_ready, reload_busy, reload_done, pal_we, q_count, pal_waddr, src_addr}, 32'd0);
    check("midrst_wdata", 32'(pal_wdata), 32'd0);
    repeat (2) tick();
    Reset_n = 1'b1;
    clear_log();
    repeat (300) tick();
    check("midrst_no_done", 32'(done_cnt), 32'd0);
    check("midrst_no_we", 32'(wa_q.size()), 32'd0);
    check("midrst_busy", 32'(reload_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/palette_update_ctrl.md
# palette_update_ctrl

Write-side controller for the 256-entry, 24-bit colour palette RAM. It shares the palette write port between two requesters: a host single-entry write queue and a bulk reload engine that copies a full palette from a synchronous source ROM. All palette writes are confined to vertical blanking so the scan-out lookup never sees a partially updated palette mid-frame.

## Interface
- ADDR_W, 8, palette index width (256 entries)
- DATA_W, 24, palette entry width ({R,G,B}, 8 bits each)
- FIFO_DEPTH, 16, host write queue depth (power of two, ≥2)

- Clk  in  1  system clock
- Reset_n  in  1  asynchronous, active-low reset
- vblank  in  1  high during vertical blanking, synchronous to Clk
- host_valid  in  1  host write request
- host_ready  out  1  queue can accept; transfer when host_valid & host_ready
- host_addr  in  ADDR_W  palette index
- host_data  in  DATA_W  colour value
- reload_req  in  1  single-cycle pulse requesting a full reload
- reload_busy  out  1  reload accepted and not yet complete
- reload_done  out  1  single-cycle pulse when reload completes
- src_addr  out  ADDR_W  source ROM address; data returned 1 cycle later
- src_data  in  DATA_W  source ROM data
- pal_we  out  1  palette RAM write enable
- pal_waddr  out  ADDR_W  palette RAM write address
- pal_wdata  out  DATA_W  palette RAM write data
- q_count  out  $clog2(FIFO_DEPTH)+1  host queue occupancy

## Operation
- Reset: every output is 0, including host_ready, q_count, reload_busy, reload_done, pal_we, pal_waddr, pal_wdata, and src_addr. The queue is empty, the FSM is in IDLE, and host_ready rises in the first cycle after Reset_n deasserts.
- Host queue: host_ready = !full. A write is enqueued on a handshake regardless of vblank. If a handshake and a dequeue occur in the same cycle while the queue is full, the enqueue is still refused, because host_ready is derived from the registered full flag.
- FSM states: IDLE, RELOAD, DRAIN.
- IDLE -> RELOAD on a pending reload and vblank=1. Otherwise IDLE -> DRAIN on a non-empty queue and vblank=1. Reload has priority when both are pending.
- reload_req is latched into a pending flag and sets reload_busy on the next cycle. A reload_req arriving while reload_busy=1 is ignored.
- RELOAD: a counter k runs 0..255. Each cycle with vblank=1, the block drives src_addr=k and increments k. A valid bit follows one cycle behind, writing pal_waddr=k and pal_wdata=src_data.
- If vblank=0, no new address is issued and k holds. Any in-flight entry still completes. Issue resumes at k in the next vblank, and the FSM stays in RELOAD.
- After entry 255 is written, reload_done pulses and reload_busy clears. The FSM then goes to DRAIN if the queue is non-empty and vblank=1, otherwise to IDLE.
- DRAIN: one queue entry is popped per cycle while vblank=1 and written in order. Host writes queued during a reload therefore land after it and override the reloaded values.
- DRAIN -> IDLE when the queue is empty or vblank=0. A newly latched reload is serviced from IDLE, not by preempting DRAIN mid-entry.
- Reset mid-operation aborts immediately. The queue is cleared, the reload is dropped, and no reload_done is issued.

## Timing
- All outputs are registered.
- Reload latency: src_addr=k is presented in cycle n, and pal_we/pal_waddr=k appear in cycle n+2. A full uninterrupted reload takes 256 issue cycles plus 2, and reload_done pulses in the cycle after the last pal_we.
- Drain latency: pal_we for a popped entry appears one cycle after the pop decision.
- Boundary write: a write decided in the last vblank cycle lands at most 2 cycles after vblank falls. Scan-out tolerates this because that interval falls in the back-porch region.
- No new issue or pop is started in a cycle where vblank=0.
- Maximum write rate is one pal_we per cycle.

## Structure
- Package pal_ctrl_pkg: ADDR_W/DATA_W constants, the state_t enum {IDLE, RELOAD, DRAIN}, and the pal_entry_t packed struct {addr, data}.
- Sub-module pal_wr_fifo: synchronous FIFO of pal_entry_t with full, empty, and count outputs and a registered full flag.
- The FSM, reload counter, and write mux live in the top level.

## Test plan
- Reset, then 3 host writes {0x05:0xFF0000, 0x06:0x00FF00, 0x07:0x0000FF} with vblank=0 -> no pal_we and q_count=3. Then raise vblank -> 3 consecutive pal_we cycles in that order, and q_count returns to 0.
- Fill the queue with 16 writes with vblank=0 -> host_ready=0. A 17th write is held until one entry drains in vblank, and no entry is lost or duplicated.
- Pulse reload_req, hold vblank=1, and use an identity ROM (data = {3{addr}}) -> 256 pal_we, addresses 0..255 with pal_wdata=0x000000..0xFFFFFF. reload_done pulses once, 259 cycles after the pulse.
- Reload with vblank dropping after 100 issues -> pal_we stops within 2 cycles. On the next vblank, writes resume at address 100 with no gap or repeat.
- Host write to 0x10:0xABCDEF queued during a reload -> the final write to 0x10 is 0xABCDEF, occurring after reload_done.
- Assert Reset_n=0 mid-reload at k=50 -> all outputs return to 0 within the same cycle, and no reload_done is issued afterwards.
